// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 FFT family (component widths up to 32 bits).
package fft_pkg;

  localparam int unsigned W_DEF    = 16;
  localparam int unsigned FRAC_DEF = 11;
  localparam int unsigned ONE      = 1 << FRAC_DEF;

  // {re,im} at the default width; other widths keep the same packing
  typedef struct packed {
    logic signed [W_DEF-1:0] re;
    logic signed [W_DEF-1:0] im;
  } cplx_t;

  function automatic int unsigned bitrev(input int unsigned n, input int unsigned bits);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < bits; i++)
      r |= ((n >> i) & 1) << (bits - 1 - i);
    return r;
  endfunction

  // Component add/sub; callers truncate to their width, which gives the mod 2**W wrap
  function automatic int cadd(input int a, input int b);
    return a + b;
  endfunction

  function automatic int csub(input int a, input int b);
    return a - b;
  endfunction

endpackage

// File: rtl/fft_bfly.sv
// Combinational radix-2 DIT butterfly: a' = a + b*t, b' = a - b*t, optional halving.
module fft_bfly
  import fft_pkg::*;
#(
  parameter int unsigned W    = W_DEF,
  parameter int unsigned FRAC = FRAC_DEF
) (
  input  logic [2*W-1:0] a,
  input  logic [2*W-1:0] b,
  input  logic [2*W-1:0] tw,
  input  logic           inv,
  input  logic           scale,
  output logic [2*W-1:0] a_out,
  output logic [2*W-1:0] b_out
);

  localparam logic signed [2*W-1:0] RND = (2*W)'((1 << FRAC) - 1);

  // Q-format product, rounded toward zero on magnitude
  function automatic logic signed [W-1:0] qmul(input logic signed [W-1:0] x,
                                               input logic signed [W-1:0] y);
    logic signed [2*W-1:0] xe, ye, p;
    xe = x;
    ye = y;
    p  = xe * ye;
    if (p < 0) p = p + RND;
    return W'(p >>> FRAC);
  endfunction

  function automatic logic [W-1:0] post(input int s, input logic sc);
    logic [W-1:0] v;
    v = W'(s);
    return sc ? {v[W-1], v[W-1:1]} : v;
  endfunction

  logic signed [W-1:0] ar, ai, br, bi, tr, ti, mr, mi;

  always_comb begin
    ar = a[2*W-1:W];
    ai = a[W-1:0];
    br = b[2*W-1:W];
    bi = b[W-1:0];
    tr = tw[2*W-1:W];
    ti = inv ? -$signed(tw[W-1:0]) : $signed(tw[W-1:0]);
    mr = W'(csub(int'(qmul(br, tr)), int'(qmul(bi, ti))));
    mi = W'(cadd(int'(qmul(br, ti)), int'(qmul(bi, tr))));
    a_out = {post(cadd(int'(ar), int'(mr)), scale), post(cadd(int'(ai), int'(mi)), scale)};
    b_out = {post(csub(int'(ar), int'(mr)), scale), post(csub(int'(ai), int'(mi)), scale)};
  end

endmodule

// File: rtl/fft_seq.sv
// Sequential in-place radix-2 DIT FFT/IFFT: bit-reversed load, one butterfly per cycle,
// natural-order unload over valid/ready.
module fft_seq
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N = 3,
  parameter int unsigned W     = W_DEF,
  parameter int unsigned FRAC  = FRAC_DEF,
  parameter bit          SCALE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W-1:0]   in_data,
  input  logic             inv,
  output logic [LOG2N-2:0] tw_idx,
  input  logic [2*W-1:0]   tw_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_data,
  output logic             busy
);

  localparam int unsigned N  = 1 << LOG2N;
  localparam int unsigned SW = $clog2(LOG2N);

  localparam logic [1:0] LOAD   = 2'd0;
  localparam logic [1:0] CALC   = 2'd1;
  localparam logic [1:0] UNLOAD = 2'd2;

  logic [1:0]       state;
  logic [LOG2N-1:0] cnt;
  logic [LOG2N-2:0] bj;
  logic [SW-1:0]    stage;
  logic             inv_r;
  logic [2*W-1:0]   mem [N];

  logic [LOG2N-1:0] jx, lowmask, pos, p, q;
  logic [2*W-1:0]   a_new, b_new;

  // p = grp*2*half + pos, q = p + half, k = pos * N/(2*half), all as mask/shift
  always_comb begin
    jx      = {1'b0, bj};
    lowmask = ~({LOG2N{1'b1}} << stage);
    pos     = jx & lowmask;
    p       = ((jx & ~lowmask) << 1) | pos;
    q       = p | (LOG2N'(1) << stage);
  end

  assign tw_idx    = (LOG2N-1)'(pos << (LOG2N - 1 - stage));
  assign in_ready  = (state == LOAD);
  assign out_valid = (state == UNLOAD);
  assign busy      = (state == CALC) || (state == UNLOAD);
  assign out_data  = mem[cnt];

  fft_bfly #(
    .W    (W),
    .FRAC (FRAC)
  ) u_bfly (
    .a     (mem[p]),
    .b     (mem[q]),
    .tw    (tw_data),
    .inv   (inv_r),
    .scale (SCALE),
    .a_out (a_new),
    .b_out (b_new)
  );

  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid)
      mem[LOG2N'(bitrev(32'(cnt), LOG2N))] <= in_data;
    else if (state == CALC) begin
      mem[p] <= a_new;
      mem[q] <= b_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      cnt   <= '0;
      bj    <= '0;
      stage <= '0;
      inv_r <= 1'b0;
    end else begin
      case (state)
        LOAD: if (in_valid) begin
          if (cnt == '0) inv_r <= inv;
          cnt <= cnt + 1'b1;
          if (&cnt) state <= CALC;
        end
        CALC: begin
          bj <= bj + 1'b1;
          if (&bj) begin
            if (stage == SW'(LOG2N - 1)) begin
              stage <= '0;
              state <= UNLOAD;
            end else begin
              stage <= stage + 1'b1;
            end
          end
        end
        UNLOAD: if (out_ready) begin
          cnt <= cnt + 1'b1;
          if (&cnt) state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_seq.sv
// Scoreboard bench for fft_seq (N=8): one unscaled and one scaled instance.
module tb_fft_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, inv, out_valid, out_ready, busy;
  logic [31:0] in_data, tw_data, out_data;
  logic [1:0]  tw_idx;
  logic        in_valid_s, in_ready_s, inv_s, out_valid_s, out_ready_s, busy_s;
  logic [31:0] in_data_s, tw_data_s, out_data_s;
  logic [1:0]  tw_idx_s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          ch;
    logic [31:0] data;
    int          tol;
    int          idx;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] frame [8];
  logic [31:0] exp_f [8];
  bit          stall_seen [2];
  logic [31:0] held [2];

  always #5 clk = ~clk;

  function automatic logic [31:0] tw_rom(input logic [1:0] k);
    case (k)
      2'd0:    return 32'h0800_0000;
      2'd1:    return 32'h05a8_fa58;
      2'd2:    return 32'h0000_f800;
      default: return 32'hfa58_fa58;
    endcase
  endfunction

  assign tw_data   = tw_rom(tw_idx);
  assign tw_data_s = tw_rom(tw_idx_s);

  fft_seq #(.LOG2N(3), .W(16), .FRAC(11), .SCALE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .inv(inv), .tw_idx(tw_idx), .tw_data(tw_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  fft_seq #(.LOG2N(3), .W(16), .FRAC(11), .SCALE(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .in_data(in_data_s), .inv(inv_s), .tw_idx(tw_idx_s), .tw_data(tw_data_s),
    .out_valid(out_valid_s), .out_ready(out_ready_s), .out_data(out_data_s), .busy(busy_s)
  );

  function automatic bit close(input logic [31:0] a, input logic [31:0] b, input int tol);
    int dr, di;
    dr = int'($signed(a[31:16])) - int'($signed(b[31:16]));
    di = int'($signed(a[15:0])) - int'($signed(b[15:0]));
    return (dr <= tol) && (dr >= -tol) && (di <= tol) && (di >= -tol);
  endfunction

  task automatic mon(input int d, input logic ov, input logic ordy, input logic [31:0] od);
    exp_t e;
    if (stall_seen[d]) begin
      checks++;
      if (!(ov && od == held[d])) begin
        errors++;
        $display("FAIL hold ch%0d: valid=%0b data=%h required valid=1 data=%h", d, ov, od, held[d]);
      end
    end
    stall_seen[d] = ov && !ordy;
    held[d]       = od;
    if (ov && ordy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected ch%0d: got %h required no output", d, od);
      end else begin
        e = exp_q.pop_front();
        if (e.ch != d || !close(od, e.data, e.tol)) begin
          errors++;
          $display("FAIL out ch%0d[%0d]: got %h required %h (+/-%0d, ch%0d)",
                   d, e.idx, od, e.data, e.tol, e.ch);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      mon(0, out_valid, out_ready, out_data);
      mon(1, out_valid_s, out_ready_s, out_data_s);
    end else begin
      stall_seen[0] = 1'b0;
      stall_seen[1] = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [31:0] x, input logic iv);
    if (d == 0) begin
      in_valid = v; in_data = x; inv = iv;
    end else begin
      in_valid_s = v; in_data_s = x; inv_s = iv;
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? in_ready : in_ready_s;
  endfunction

  task automatic send_frame(input int d, input logic iv);
    int budget;
    for (int n = 0; n < 8; n++) begin
      drive(d, 1'b1, frame[n], (n == 0) ? iv : ~iv);
      budget = 0;
      @(negedge clk);
      while (!rdy(d) && budget < 200) begin
        @(negedge clk);
        budget++;
      end
      if (!rdy(d)) begin
        checks++;
        errors++;
        $display("FAIL accept ch%0d[%0d]: in_ready=0 required 1", d, n);
      end
      @(posedge clk);
      #1;
    end
    drive(d, 1'b0, '0, 1'b0);
  endtask

  task automatic push_exp(input int d, input int tol);
    for (int n = 0; n < 8; n++) exp_q.push_back('{ch: d, data: exp_f[n], tol: tol, idx: n});
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 300) begin
      @(negedge clk);
      b++;
    end
    check("drain pending", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] fv, input logic [31:0] ev);
    for (int n = 0; n < 8; n++) begin
      frame[n] = fv;
      exp_f[n] = ev;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, b;
    rst_n = 1'b0;
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    out_ready   = 1'b1;
    out_ready_s = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset tw_idx", tw_idx, 0);
    @(posedge clk);
    #1;

    // impulse -> flat spectrum, with first-output latency
    fill(32'h0, 32'h0800_0000);
    frame[0] = 32'h0800_0000;
    push_exp(0, 0);
    send_frame(0, 1'b0);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 13);
    drain();

    // delayed impulse through the inverse: e^{+j2pik/8}
    fill(32'h0, 32'h0);
    frame[1] = 32'h0800_0000;
    exp_f = '{32'h0800_0000, 32'h05a8_05a8, 32'h0000_0800, 32'hfa58_05a8,
              32'hf800_0000, 32'hfa58_fa58, 32'h0000_f800, 32'h05a8_fa58};
    push_exp(0, 0);
    send_frame(0, 1'b1);
    drain();

    // DC, unscaled
    fill(32'h0800_0000, 32'h0);
    exp_f[0] = 32'h4000_0000;
    push_exp(0, 0);
    send_frame(0, 1'b0);
    drain();

    // cosine bin 2, stray in_valid during CALC, stall holding f2
    frame = '{32'h07ff_0000, 32'h0, 32'hf801_0000, 32'h0,
              32'h07ff_0000, 32'h0, 32'hf801_0000, 32'h0};
    exp_f = '{32'h0, 32'h0, 32'h1ffc_0000, 32'h0, 32'h0, 32'h0, 32'h1ffc_0000, 32'h0};
    push_exp(0, 2);
    send_frame(0, 1'b0);
    drive(0, 1'b1, 32'hdead_beef, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("in_ready during CALC", in_ready, 0);
    end
    @(posedge clk);
    #1 drive(0, 1'b0, '0, 1'b0);
    b = 0;
    @(negedge clk);
    while (!out_valid && b < 100) begin
      @(negedge clk);
      b++;
    end
    check("unload reached", out_valid, 1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // scaled DC through the inverse
    fill(32'h0800_0000, 32'h0);
    exp_f[0] = 32'h0800_0000;
    push_exp(1, 0);
    send_frame(1, 1'b1);
    drain();

    // scaled inverse of the cosine spectrum recovers the cosine
    frame = '{32'h0, 32'h0, 32'h1ffc_0000, 32'h0, 32'h0, 32'h0, 32'h1ffc_0000, 32'h0};
    exp_f = '{32'h07ff_0000, 32'h0, 32'hf801_0000, 32'h0,
              32'h07ff_0000, 32'h0, 32'hf801_0000, 32'h0};
    push_exp(1, 3);
    send_frame(1, 1'b1);
    drain();

    // reset during CALC stage 1 aborts the frame
    fill(32'h0, 32'h0800_0000);
    frame[0] = 32'h0800_0000;
    send_frame(0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("busy before abort", busy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort in_ready", in_ready, 1);
    check("abort out_valid", out_valid, 0);
    check("abort busy", busy, 0);
    @(posedge clk);
    #1;
    push_exp(0, 0);
    send_frame(0, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_seq.md
Name: fft_seq

Overview:
- Parametrised, sequential radix-2 decimation-in-time FFT/IFFT over N = 2**LOG2N complex points.
- Successor to the team's fixed 8-point combinational FFT. Uses the same packed complex format: {re[W-1:0], im[W-1:0]}, two's complement, FRAC fractional bits.
- Accepts a frame over a valid/ready stream, computes in place with one butterfly per cycle, then returns the frame in natural order.
- Twiddles are read from an external table port; optional per-stage scaling and an inverse mode are added.

Parameters:
- LOG2N, 3, log2 of point count (N = 8 default; legal range 2..10)
- W, 16, width of each real/imaginary component
- FRAC, 11, fractional bits (default is Q4.11; 1.0 = 0x0800)
- SCALE, 0, 1 = arithmetic shift right by 1 after every stage (output divided by N)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts a sample (LOAD state only)
- in_data  in  2W  complex input sample {re,im}
- inv  in  1  sampled with the first accepted sample of a frame; 1 = IFFT (conjugate twiddles)
- tw_idx  out  LOG2N-1  twiddle index k, valid every CALC cycle
- tw_data  in  2W  W_N^k = exp(-j2πk/N) {re,im}, combinational return in the same cycle
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts output
- out_data  out  2W  complex output sample, natural order
- busy  out  1  high in CALC and UNLOAD

Behaviour:
- Reset (async, rst_n=0):
  - state=LOAD; all counters = 0; in_ready=1 after release; out_valid=0; busy=0; tw_idx=0.
  - The sample array is not cleared.
- LOAD:
  - The n-th accepted sample (in_valid & in_ready) is written to array[bitrev(n)].
  - inv is latched with n=0.
  - After the N-th acceptance: state→CALC, in_ready=0 from the next cycle.
- CALC:
  - Stage s = 0..LOG2N-1; half = 2**s.
  - Butterfly j = 0..N/2-1 within each stage:
    - grp = j/half, pos = j%half.
    - p = grp*2*half + pos, q = p + half.
    - k = pos * (N/(2*half)); tw_idx = k.
  - Each butterfly does a combinational read of array[p], array[q] and writes back in the same cycle.
  - Twiddle: t = tw_data, with t.im negated if inv.
  - m = array[q]*t (complex multiply):
    - Each partial product is a full 2W signed product; bits [FRAC+W-1:FRAC] are taken after truncation toward zero on magnitude.
    - re = ar*tr - ai*ti; im = ar*ti + ai*tr. Add/sub wrap mod 2**W.
  - Write-back: array[p] = array[p]+m, array[q] = array[p]-m. Both wrap mod 2**W; each component is arithmetically shifted right by 1 when SCALE=1.
  - CALC lasts exactly LOG2N*N/2 cycles, after which state→UNLOAD.
- UNLOAD:
  - out_valid=1; out_data=array[n] for n = 0..N-1.
  - n advances only on out_valid & out_ready. out_data is held stable while out_ready=0.
  - After the N-th transfer: out_valid=0 next cycle, state→LOAD, in_ready=1.
- Latency: first output is valid N/2*LOG2N cycles after the cycle the N-th input is accepted, +1 (registered state change).
- Throughput: no overlap between frames; in_ready=0 during CALC/UNLOAD. in_valid outside LOAD is ignored.
- inv changes mid-frame have no effect.
- Reset mid-operation aborts the frame immediately; no partial output is emitted.

Decomposition:
- Shared package fft_pkg holds:
  - Complex typedef {re,im} parametrised on W.
  - FRAC default and the Q-format constants ONE = 1<<FRAC.
  - Function bitrev(LOG2N).
  - Functions cadd/csub (wrapping).
- One sub-module, fft_bfly: combinational radix-2 butterfly (inputs a, b, twiddle, inv, scale; outputs a', b'). It is reused by future pipelined variants.
- FSM, counters and sample array stay in fft_seq.

Test Plan:
- Impulse: N=8, SCALE=0, x0=0x08000000, others 0, twiddle table W0=08000000, W1=05a8fa58, W2=0000f800, W3=fa58fa58 → all 8 outputs 0x08000000.
- DC: all inputs 0x08000000, SCALE=0 → f0=0x40000000, f1..f7=0x00000000. Same stimulus with SCALE=1 → f0=0x08000000, others 0.
- Inverse round-trip: run random bounded inputs (|x| < 0.5) through FFT with SCALE=0, feed the result back with inv=1, SCALE=1 → each output within ±LOG2N LSB of the original x.
- Cosine bin 2: x[n] = {0x07ff,0xf801,...} pattern cos(2πn·2/8) → f2 and f6 ≈ 0x1ffc0000, others ≈ 0 (±2 LSB).
- Backpressure: hold out_ready=0 for 5 cycles mid-UNLOAD → out_data/out_valid stable, no sample dropped or duplicated. Assert in_valid during CALC → ignored; next frame unaffected.
- Reset: assert rst_n=0 during CALC stage 1 → in_ready=1, out_valid=0, busy=0 after release. A fresh impulse frame then produces the impulse response.
